// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM micro-sequencer.
// The control word struct mirrors the microcode ROM bit layout exactly.
package ctrl_pkg;

  typedef logic [4:0] upc_t;

  localparam logic [4:0] FETCH    = 5'h00;
  localparam logic [4:0] DECODE   = 5'h01;
  localparam logic [4:0] MEMADR   = 5'h02;
  localparam logic [4:0] MEMREAD  = 5'h03;
  localparam logic [4:0] MEMWB    = 5'h04;
  localparam logic [4:0] MEMWRITE = 5'h05;
  localparam logic [4:0] EXEC_R   = 5'h06;
  localparam logic [4:0] EXEC_I   = 5'h07;
  localparam logic [4:0] ALUWB    = 5'h08;
  localparam logic [4:0] BRANCH   = 5'h09;
  localparam logic [4:0] BL       = 5'h0A;
  localparam logic [4:0] MEMREADB = 5'h0B;

  localparam logic [4:0] DISP_DECODE = 5'h1F;
  localparam logic [4:0] DISP_MEM    = 5'h1E;

  typedef struct packed {
    logic [12:0] rsvd;
    logic        ldrb;
    logic        alu_op;
    logic        b;
    logic        next_pc;
    logic        reg_w;
    logic        mem_w;
    logic        ir_write;
    logic        adr_src;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    upc_t        next_adr;
  } ctrl_word_t;

endpackage

// File: rtl/dispatch_decode.sv
// Resolves the decode and memory dispatch codes into concrete micro-addresses.
// Non-dispatch NextAdr values pass straight through.
module dispatch_decode
  import ctrl_pkg::*;
(
  input  upc_t       next_adr,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  output upc_t       next_upc,
  output logic       illegal
);

  // Only the I, L/link, B and S bits steer dispatch.
  logic unused_funct;
  assign unused_funct = ^{funct[3], funct[1]};

  always_comb begin
    next_upc = next_adr;
    illegal  = 1'b0;
    if (next_adr == DISP_DECODE) begin
      case (op)
        2'b00:   next_upc = funct[5] ? EXEC_I : EXEC_R;
        2'b01:   next_upc = MEMADR;
        2'b10:   next_upc = funct[4] ? BL : BRANCH;
        default: begin
          next_upc = FETCH;
          illegal  = 1'b1;
        end
      endcase
    end else if (next_adr == DISP_MEM) begin
      if (!funct[0])     next_upc = MEMWRITE;
      else if (funct[2]) next_upc = MEMREADB;
      else               next_upc = MEMREAD;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC owner for the multicycle ARM control unit: sequences the microcode
// ROM, gates write enables with the condition check and keeps perf counters.
module micro_sequencer
  import ctrl_pkg::*;
#(
  parameter int UPC_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [UPC_W-1:0] rom_adr,
  input  logic [31:0]      rom_dout,
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  input  logic             cond_ex,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_write,
  output logic             adr_src,
  output logic             alu_op,
  output logic             ldrb,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  ctrl_word_t cw;
  upc_t       upc;
  upc_t       next_upc;
  logic       disp_illegal;
  logic       mem_state;
  logic       stall;
  logic       advance;
  logic       enable_ok;
  logic       unused_rsvd;

  assign cw          = ctrl_word_t'(rom_dout);
  assign unused_rsvd = ^cw.rsvd;
  assign rom_adr     = upc;

  dispatch_decode u_dispatch (
    .next_adr (cw.next_adr),
    .op       (op),
    .funct    (funct),
    .next_upc (next_upc),
    .illegal  (disp_illegal)
  );

  // mem_ready handshake: a memory state (IRWrite or AdrSrc) completes only in
  // a cycle where mem_ready=1; until then uPC holds and only mem_write stays up.
  assign mem_state = cw.ir_write | cw.adr_src;
  assign stall     = mem_state & ~mem_ready;
  assign advance   = ~stall;
  assign enable_ok = ~reset & ~stall;

  assign pc_write   = enable_ok & (cw.next_pc | (cw.b & cond_ex));
  assign ir_write   = enable_ok & cw.ir_write;
  assign reg_write  = enable_ok & cw.reg_w & cond_ex;
  assign mem_write  = ~reset & cw.mem_w & cond_ex;
  assign adr_src    = cw.adr_src;
  assign alu_op     = cw.alu_op;
  assign ldrb       = cw.ldrb;
  assign result_src = cw.result_src;
  assign alu_src_a  = cw.alu_src_a;
  assign alu_src_b  = cw.alu_src_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc       <= FETCH;
      illegal   <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      illegal   <= advance & disp_illegal;
      if (advance) begin
        upc <= next_upc;
        // Retirement is the return to Fetch from somewhere else.
        if (next_upc == FETCH && upc != FETCH)
          instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: bench-side microcode ROM, instruction-level
// reference model, directed test-plan runs and randomized instruction streams.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rom_adr;
  logic [31:0] rom_dout;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        cond_ex;
  logic        mem_ready;
  logic        pc_write, ir_write, reg_write, mem_write;
  logic        adr_src, alu_op, ldrb;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic        illegal;
  logic [31:0] cycle_cnt, instr_cnt;

  logic [31:0] rom [32];
  assign rom_dout = rom[rom_adr];

  micro_sequencer #(.UPC_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .rom_adr(rom_adr), .rom_dout(rom_dout),
    .op(op), .funct(funct), .cond_ex(cond_ex), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_write(mem_write), .adr_src(adr_src), .alu_op(alu_op), .ldrb(ldrb),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .illegal(illegal), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [4:0]  exp_q[$];
  logic [4:0]  m_upc;
  logic [31:0] m_cyc, m_ins;
  logic        m_ill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input bit lb, input bit ao, input bit b, input bit npc,
                                     input bit rw, input bit mw, input bit irw, input bit as,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [4:0] nadr);
    logic [12:0] junk;
    junk = 13'($urandom);
    return {junk, lb, ao, b, npc, rw, mw, irw, as, rs, sa, sb, nadr};
  endfunction

  // Where an instruction goes after a dispatch point, by instruction class.
  function automatic logic [4:0] ref_next(input logic [4:0] nadr, input logic [1:0] o,
                                          input logic [5:0] f, output bit bad);
    bad = 0;
    if (nadr == 5'h1F) begin
      if (o == 2'b11) begin bad = 1; return 5'h00; end
      if (o == 2'b01) return 5'h02;
      if (o == 2'b10) return f[4] ? 5'h0A : 5'h09;
      return f[5] ? 5'h07 : 5'h06;
    end
    if (nadr == 5'h1E) begin
      if (f[0] == 1'b0) return 5'h05;
      return f[2] ? 5'h0B : 5'h03;
    end
    return nadr;
  endfunction

  // Called just after a rising edge; checks mid-cycle, then advances the model.
  task automatic step(input logic [1:0] o, input logic [5:0] f, input logic c, input logic r);
    logic [31:0] w;
    logic [4:0]  nxt;
    bit          stalled, bad;
    op = o; funct = f; cond_ex = c; mem_ready = r;
    @(negedge clk);
    w = rom[m_upc];
    stalled = (w[12] || w[11]) && !r;
    if (exp_q.size() > 0) check("path", 32'(rom_adr), 32'(exp_q.pop_front()));
    check("rom_adr", 32'(rom_adr), 32'(m_upc));
    check("pc_write", 32'(pc_write), 32'(!stalled && (w[15] || (w[16] && c))));
    check("ir_write", 32'(ir_write), 32'(!stalled && w[12]));
    check("reg_write", 32'(reg_write), 32'(!stalled && w[14] && c));
    check("mem_write", 32'(mem_write), 32'(w[13] && c));
    check("adr_src", 32'(adr_src), 32'(w[11]));
    check("alu_op", 32'(alu_op), 32'(w[17]));
    check("ldrb", 32'(ldrb), 32'(w[18]));
    check("result_src", 32'(result_src), 32'(w[10:9]));
    check("alu_src_a", 32'(alu_src_a), 32'(w[8:7]));
    check("alu_src_b", 32'(alu_src_b), 32'(w[6:5]));
    check("illegal", 32'(illegal), 32'(m_ill));
    check("cycle_cnt", cycle_cnt, m_cyc);
    check("instr_cnt", instr_cnt, m_ins);
    nxt = ref_next(w[4:0], o, f, bad);
    @(posedge clk);
    #1;
    m_cyc++;
    m_ill = 1'b0;
    if (!stalled) begin
      m_ill = bad;
      if (nxt == 5'h00 && m_upc != 5'h00) m_ins++;
      m_upc = nxt;
    end
  endtask

  // One instruction from Fetch back to Fetch; stall_n wait cycles at stall_at.
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic c,
                           input logic [4:0] stall_at, input int stall_n);
    int n = 0;
    int waits = 0;
    do begin
      if (m_upc == stall_at && waits < stall_n) begin
        waits++;
        step(o, f, c, 1'b0);
      end else begin
        step(o, f, c, 1'b1);
      end
      n++;
    end while (m_upc != 5'h00 && n < 30);
    check("instr_done", 32'(m_upc), 32'h0);
  endtask

  task automatic model_reset();
    m_upc = 5'h00; m_cyc = 0; m_ins = 0; m_ill = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = mk(0,0,0,1,0,0,1,0,2'd2,2'd1,2'd2,5'h01);
    rom[1]  = mk(0,0,0,0,0,0,0,0,2'd2,2'd1,2'd2,5'h1F);
    rom[2]  = mk(0,0,0,0,0,0,0,0,2'd0,2'd0,2'd1,5'h1E);
    rom[3]  = mk(0,0,0,0,0,0,0,1,2'd0,2'd0,2'd0,5'h04);
    rom[4]  = mk(0,0,0,0,1,0,0,0,2'd1,2'd0,2'd0,5'h00);
    rom[5]  = mk(0,0,0,0,0,1,0,1,2'd0,2'd0,2'd0,5'h00);
    rom[6]  = mk(0,1,0,0,0,0,0,0,2'd0,2'd0,2'd0,5'h08);
    rom[7]  = mk(0,1,0,0,0,0,0,0,2'd0,2'd0,2'd1,5'h08);
    rom[8]  = mk(0,0,0,0,1,0,0,0,2'd0,2'd0,2'd0,5'h00);
    rom[9]  = mk(0,0,1,0,0,0,0,0,2'd2,2'd0,2'd1,5'h00);
    rom[10] = mk(0,0,1,0,1,0,0,0,2'd2,2'd0,2'd1,5'h00);
    rom[11] = mk(1,0,0,0,0,0,0,1,2'd0,2'd0,2'd0,5'h04);

    reset = 1'b1; op = 2'b00; funct = 6'h00; cond_ex = 1'b1; mem_ready = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_upc", 32'(rom_adr), 32'h0);
    check("rst_cyc", cycle_cnt, 32'h0);
    check("rst_ins", instr_cnt, 32'h0);
    check("rst_ill", 32'(illegal), 32'h0);
    check("rst_en", 32'({pc_write, ir_write, reg_write, mem_write}), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ADD register
    exp_q = '{5'h00, 5'h01, 5'h06, 5'h08};
    run_instr(2'b00, 6'b001000, 1'b1, 5'h1F, 0);
    check("add_cyc", cycle_cnt, 32'd4);
    check("add_ins", instr_cnt, 32'd1);

    // LDRB with two wait cycles in MemReadByte
    exp_q = '{5'h00, 5'h01, 5'h02, 5'h0B, 5'h0B, 5'h0B, 5'h04};
    run_instr(2'b01, 6'b010101, 1'b1, 5'h0B, 2);
    check("ldrb_cyc", cycle_cnt, 32'd11);
    check("ldrb_ins", instr_cnt, 32'd2);

    // STR with condition failed
    exp_q = '{5'h00, 5'h01, 5'h02, 5'h05};
    run_instr(2'b01, 6'b011000, 1'b0, 5'h1F, 0);
    check("str_ins", instr_cnt, 32'd3);

    // BL taken and not taken
    exp_q = '{5'h00, 5'h01, 5'h0A};
    run_instr(2'b10, 6'b010000, 1'b1, 5'h1F, 0);
    exp_q = '{5'h00, 5'h01, 5'h0A};
    run_instr(2'b10, 6'b010000, 1'b0, 5'h1F, 0);
    check("bl_ins", instr_cnt, 32'd5);

    // Undefined op from Decode
    exp_q = '{5'h00, 5'h01};
    run_instr(2'b11, 6'b000000, 1'b1, 5'h1F, 0);
    check("ill_pulse", 32'(illegal), 32'h1);
    check("ill_ins", instr_cnt, 32'd6);
    step(2'b00, 6'b001000, 1'b1, 1'b1);
    check("ill_clear", 32'(illegal), 32'h0);
    run_instr(2'b00, 6'b001000, 1'b1, 5'h1F, 0);

    // Reset while stalled in MemRead
    model_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h03};
    for (int i = 0; i < 5; i++) step(2'b01, 6'b011001, 1'b1, i < 3);
    #2;
    reset = 1'b1;
    #1;
    check("arst_upc", 32'(rom_adr), 32'h0);
    check("arst_cyc", cycle_cnt, 32'h0);
    check("arst_ins", instr_cnt, 32'h0);
    check("arst_en", 32'({pc_write, ir_write, reg_write, mem_write}), 32'h0);
    mem_ready = 1'b1;
    @(negedge clk);
    check("arst_en_hold", 32'({pc_write, ir_write, reg_write, mem_write}), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    exp_q = '{5'h00, 5'h01};
    step(2'b00, 6'b101000, 1'b1, 1'b1);
    step(2'b00, 6'b101000, 1'b1, 1'b1);
    exp_q.delete();
    run_instr(2'b00, 6'b101000, 1'b1, 5'h1F, 0);

    // Randomized instruction stream with random wait states
    for (int k = 0; k < 60; k++) begin
      logic [1:0] o;
      logic [5:0] f;
      logic       c;
      int         n;
      o = 2'($urandom_range(0, 3));
      f = 6'($urandom);
      c = 1'($urandom);
      n = 0;
      do begin
        step(o, f, c, $urandom_range(0, 3) != 0);
        n++;
      end while (m_upc != 5'h00 && n < 40);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
